gpio_in_conditioner: RTL and testbench



---
 rtl/gpio_in_conditioner_pkg.sv | 27 ++
 rtl/gpio_in_conditioner_debounce_bit.sv | 70 +++++++
 rtl/gpio_in_conditioner.sv | 68 ++++++
 tb/tb_gpio_in_conditioner.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/gpio_in_conditioner_pkg.sv
// Shared constants for the gpio_in front-end: default widths, word layout and
// the two states of the per-bit debouncer.
package gpio_pkg;

    localparam int GPIO_W        = 32;
    localparam int SW_W_DEF      = 18;
    localparam int KEY_W_DEF     = 4;
    localparam int DB_CYCLES_DEF = 50000;
    localparam int DB_CYCLES_MAX = (1 << 20) - 1;

    // Field offsets inside gpio_in; key and event fields follow the switches.
    localparam int SW_LSB = 0;

    function automatic int key_lsb(input int sw_w);
        return SW_LSB + sw_w;
    endfunction

    function automatic int evt_lsb(input int sw_w, input int key_w);
        return SW_LSB + sw_w + key_w;
    endfunction

    typedef enum logic {
        DB_STABLE   = 1'b0,
        DB_COUNTING = 1'b1
    } db_state_e;

endpackage

// File: rtl/gpio_in_conditioner_debounce_bit.sv
// One input bit: 2-flop synchroniser followed by a stability-counter debouncer.
// o_rise is high for the cycle in which the accepted level is about to go 0->1.
module debounce_bit
    import gpio_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_stable,
    output logic o_rise
);

    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;

    db_state_e        w_state;
    logic             w_stable_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_stable <= w_stable_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // Any cycle where the synchronised level matches the accepted one resets the count.
    always_comb begin
        w_state      = (r_sync2 != r_stable) ? DB_COUNTING : DB_STABLE;
        w_stable_nxt = r_stable;
        w_cnt_nxt    = '0;
        o_rise       = 1'b0;
        case (w_state)
            DB_STABLE: begin
                w_cnt_nxt = '0;
            end
            DB_COUNTING: begin
                if (r_cnt == CNT_LAST) begin
                    w_stable_nxt = r_sync2;
                    o_rise       = r_sync2;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
        endcase
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/gpio_in_conditioner.sv
// Conditions board switches and push-buttons into the CPU's gpio_in word:
// synchronised, debounced levels plus sticky key-press event flags.
module gpio_in_conditioner
    import gpio_pkg::*;
#(
    parameter int SW_W      = SW_W_DEF,
    parameter int KEY_W     = KEY_W_DEF,
    parameter int DB_CYCLES = DB_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [SW_W-1:0]   sw_raw,
    input  logic [KEY_W-1:0]  key_n_raw,
    input  logic [KEY_W-1:0]  evt_clr,
    output logic [GPIO_W-1:0] gpio_in,
    output logic              evt_pending
);

    localparam int N_BITS   = SW_W + KEY_W;
    localparam int KEY_LSB_L = key_lsb(SW_W);
    localparam int EVT_LSB_L = evt_lsb(SW_W, KEY_W);

    if ((SW_W + 2 * KEY_W > GPIO_W) || (DB_CYCLES < 2) || (DB_CYCLES > DB_CYCLES_MAX)) begin : g_bad_cfg
        $fatal(1, "gpio_in_conditioner: illegal SW_W/KEY_W/DB_CYCLES combination");
    end

    logic [N_BITS-1:0] w_raw;
    logic [N_BITS-1:0] w_stable;
    logic [N_BITS-1:0] w_rise;
    logic [KEY_W-1:0]  r_evt;
    logic              w_unused_sw_rise;

    // Keys are inverted before synchronising so every internal bit is 1 = active.
    assign w_raw = {~key_n_raw, sw_raw};

    for (genvar gi = 0; gi < N_BITS; gi++) begin : g_db
        debounce_bit #(
            .DB_CYCLES(DB_CYCLES)
        ) u_db (
            .clk     (clk),
            .rst     (rst),
            .i_raw   (w_raw[gi]),
            .o_stable(w_stable[gi]),
            .o_rise  (w_rise[gi])
        );
    end

    assign w_unused_sw_rise = ^w_rise[SW_W-1:0];

    // A press on the same edge as its clear keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_evt <= '0;
        end else begin
            r_evt <= (r_evt & ~evt_clr) | w_rise[N_BITS-1:SW_W];
        end
    end

    always_comb begin
        gpio_in                       = '0;
        gpio_in[SW_LSB +: SW_W]       = w_stable[SW_W-1:0];
        gpio_in[KEY_LSB_L +: KEY_W]   = w_stable[N_BITS-1:SW_W];
        gpio_in[EVT_LSB_L +: KEY_W]   = r_evt;
    end

    assign evt_pending = |r_evt;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed bench for gpio_in_conditioner with DB_CYCLES=4 (accept after 6 edges).
module tb_gpio_in_conditioner;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] sw_raw;
    logic [3:0]  key_n_raw;
    logic [3:0]  evt_clr;
    logic [31:0] gpio_in;
    logic        evt_pending;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gpio_in_conditioner #(
        .SW_W     (18),
        .KEY_W    (4),
        .DB_CYCLES(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_raw     (sw_raw),
        .key_n_raw  (key_n_raw),
        .evt_clr    (evt_clr),
        .gpio_in    (gpio_in),
        .evt_pending(evt_pending)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    initial begin
        // Reset held with every input active.
        rst       = 1'b1;
        sw_raw    = '1;
        key_n_raw = '0;
        evt_clr   = '0;
        #2 rst = 1'b0;
        #1;
        chk("rst_gpio_async", gpio_in, 32'h0);
        chk("rst_pend_async", {31'b0, evt_pending}, 32'h0);
        tick(3);
        chk("rst_gpio_held", gpio_in, 32'h0);
        chk("rst_pend_held", {31'b0, evt_pending}, 32'h0);
        sw_raw    = '0;
        key_n_raw = '1;
        rst       = 1'b1;
        tick(8);
        chk("idle_gpio", gpio_in, 32'h0);

        // Latency of a clean switch change.
        sw_raw[0] = 1'b1;
        tick(5);
        chk("lat_edge5", gpio_in, 32'h0000_0000);
        tick(1);
        chk("lat_edge6", gpio_in, 32'h0000_0001);

        // Bounce on sw[3]: accepted 6 edges after the last transition, never before.
        sw_raw[3] = 1'b1;
        tick(2);
        sw_raw[3] = 1'b0;
        tick(1);
        sw_raw[3] = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            chk($sformatf("bounce_e%0d", i), gpio_in, (i == 6) ? 32'h0000_0009 : 32'h0000_0001);
        end

        // A pulse shorter than DB_CYCLES is rejected.
        sw_raw[5] = 1'b1;
        tick(3);
        sw_raw[5] = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick(1);
            chk($sformatf("short_pulse_e%0d", i), gpio_in, 32'h0000_0009);
        end

        // Key 1 press, release and clear.
        key_n_raw[1] = 1'b0;
        tick(5);
        chk("key1_edge5", gpio_in, 32'h0000_0009);
        tick(1);
        chk("key1_edge6", gpio_in, 32'h0088_0009);
        chk("key1_pend", {31'b0, evt_pending}, 32'h1);
        tick(4);
        key_n_raw[1] = 1'b1;
        tick(5);
        chk("key1_rel_e5", gpio_in, 32'h0088_0009);
        tick(1);
        chk("key1_rel_e6", gpio_in, 32'h0080_0009);
        chk("key1_rel_pend", {31'b0, evt_pending}, 32'h1);
        evt_clr = 4'b0010;
        tick(1);
        evt_clr = 4'b0000;
        chk("key1_clr", gpio_in, 32'h0000_0009);
        chk("key1_clr_pend", {31'b0, evt_pending}, 32'h0);

        // Clearing flags that are already clear changes nothing.
        evt_clr = 4'b1111;
        tick(1);
        evt_clr = 4'b0000;
        chk("clr_idle", gpio_in, 32'h0000_0009);

        // Set and clear of key 2 on the same edge: set wins.
        key_n_raw[2] = 1'b0;
        tick(5);
        evt_clr = 4'b0100;
        tick(1);
        evt_clr = 4'b0000;
        chk("collide", gpio_in, 32'h0110_0009);
        chk("collide_pend", {31'b0, evt_pending}, 32'h1);
        key_n_raw[2] = 1'b1;
        tick(6);
        chk("collide_rel", gpio_in, 32'h0100_0009);
        evt_clr = 4'b0100;
        tick(1);
        evt_clr = 4'b0000;
        chk("collide_clr", gpio_in, 32'h0000_0009);

        // Reset in the middle of a key-0 count, key held through release.
        key_n_raw[0] = 1'b0;
        tick(4);
        rst = 1'b0;
        #1;
        chk("midrst_async", gpio_in, 32'h0);
        tick(3);
        chk("midrst_held", gpio_in, 32'h0);
        chk("midrst_pend", {31'b0, evt_pending}, 32'h0);
        rst = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            chk($sformatf("postrst_e%0d", i), gpio_in, (i == 6) ? 32'h0044_0009 : 32'h0000_0000);
        end
        chk("postrst_pend", {31'b0, evt_pending}, 32'h1);
        evt_clr = 4'b0001;
        tick(1);
        evt_clr = 4'b0000;
        chk("postrst_clr", gpio_in, 32'h0004_0009);
        tick(8);
        chk("postrst_once", gpio_in, 32'h0004_0009);
        chk("postrst_once_pend", {31'b0, evt_pending}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
